// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// Holds the controller state enum and default parameter values.
package seq_det_pkg;

  localparam int PAT_W_DEF = 3;
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_window.sv
// Serial history window with fill tracking and pattern compare.
// Ports: clk, rst_n, clear, shift_en, data, pattern -> hit.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W:0]   w_cat;
  logic [PAT_W-1:0] w_next;
  logic             w_full;

  assign w_cat  = {r_hist, data};
  assign w_next = w_cat[PAT_W-1:0];
  // window is full once this bit lands
  assign w_full = int'(r_fill) >= PAT_W - 1;
  assign hit    = w_full && (w_next == pattern);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_hist <= w_next;
      if (int'(r_fill) < PAT_W)
        r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: counts overlapping pattern hits in a serial frame.
// In: clk rst_n start abort cfg_* data_valid data; out: busy match cnt ovf done.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic             data_valid,
  input  logic             data,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow,
  output logic             done
);

  state_t r_state;
  state_t w_next;

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bits;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_match;

  logic w_accept;
  logic w_shift;
  logic w_last;
  logic w_hit;
  logic w_sat;

  assign w_accept = (r_state == IDLE) && start;
  assign w_shift  = (r_state == RUN) && data_valid;
  // RUN is only entered with r_len >= 1
  assign w_last   = w_shift && (r_bits == r_len - 1'b1);
  assign w_sat    = &r_cnt;

  seq_det_window #(
    .PAT_W(PAT_W)
  ) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_accept),
    .shift_en(w_shift),
    .data    (data),
    .pattern (r_pat),
    .hit     (w_hit)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start)
          w_next = (cfg_frame_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)
          w_next = IDLE;
        else if (w_last)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_shift && w_hit;
      if (w_accept) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_frame_len;
        r_bits <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else if (w_shift) begin
        r_bits <= r_bits + 1'b1;
        if (w_hit) begin
          if (w_sat)
            r_ovf <= 1'b1;
          else
            r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE) && !abort;
  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl with directed frames.
// Expected match/done events are queued; a monitor pops and compares.
module tb_seq_detect_ctrl;

  localparam int PW = 3;
  localparam int LW = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [PW-1:0] cfg_pattern;
  logic [LW-1:0] cfg_frame_len;
  logic          data_valid;
  logic          data;
  logic          busy;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          overflow;
  logic          done;

  typedef struct {
    bit is_done;
    int cnt;
    bit ovf;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  seq_detect_ctrl #(
    .PAT_W(PW),
    .LEN_W(LW),
    .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_pattern  (cfg_pattern),
    .cfg_frame_len(cfg_frame_len),
    .data_valid   (data_valid),
    .data         (data),
    .busy         (busy),
    .match        (match),
    .match_cnt    (match_cnt),
    .overflow     (overflow),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(bit d, int c, bit o);
    ev_t e;
    e.is_done = d;
    e.cnt     = c;
    e.ovf     = o;
    q.push_back(e);
  endtask

  task automatic pop_cmp(bit d, string nm);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event, cnt %0d", nm, match_cnt);
    end else begin
      e = q.pop_front();
      chk({nm, "_kind"}, 32'(d), 32'(e.is_done));
      chk({nm, "_cnt"}, 32'(match_cnt), e.cnt);
      chk({nm, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (match) pop_cmp(1'b0, "match");
      if (done) begin
        pop_cmp(1'b1, "done");
        chk("busy_in_done", 32'(busy), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(logic [PW-1:0] p, logic [LW-1:0] n);
    start         = 1'b1;
    cfg_pattern   = p;
    cfg_frame_len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(logic b);
    data_valid = 1'b1;
    data       = b;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic settle(string nm, int cnt);
    repeat (4) tick();
    chk({nm, "_q_empty"}, q.size(), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_cnt"}, 32'(match_cnt), cnt);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_pattern   = '0;
    cfg_frame_len = '0;
    data_valid    = 1'b0;
    data          = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic: 101 over 10101
    push_ev(0, 1, 0);
    push_ev(0, 2, 0);
    push_ev(1, 2, 0);
    start_frame(3'b101, 8'd5);
    chk("basic_busy", 32'(busy), 1);
    foreach (q[i]) ;
    send_bit(1);
    send_bit(0);
    send_bit(1);
    send_bit(0);
    send_bit(1);
    settle("basic", 2);

    // gapped valid with toggling invalid data
    push_ev(0, 1, 0);
    push_ev(1, 1, 0);
    start_frame(3'b101, 8'd4);
    begin
      logic [3:0] bits;
      bits = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
        send_bit(bits[i]);
        data = ~bits[i];
        tick();
        data = bits[i];
        tick();
      end
    end
    settle("gap", 1);

    // zero length frame
    push_ev(1, 0, 0);
    start_frame(3'b101, 8'd0);
    settle("zero", 0);

    // shorter than the window
    push_ev(1, 0, 0);
    start_frame(3'b011, 8'd2);
    send_bit(1);
    send_bit(1);
    settle("short", 0);

    // saturation at 3, overflow from the 4th hit
    push_ev(0, 1, 0);
    push_ev(0, 2, 0);
    push_ev(0, 3, 0);
    push_ev(0, 3, 1);
    push_ev(0, 3, 1);
    push_ev(0, 3, 1);
    push_ev(1, 3, 1);
    start_frame(3'b111, 8'd8);
    repeat (8) send_bit(1);
    settle("sat", 3);
    chk("sat_ovf", 32'(overflow), 1);
    push_ev(1, 0, 0);
    start_frame(3'b101, 8'd0);
    chk("restart_cnt", 32'(match_cnt), 0);
    chk("restart_ovf", 32'(overflow), 0);
    settle("restart", 0);

    // start ignored in RUN, then abort
    push_ev(0, 1, 0);
    start_frame(3'b101, 8'd4);
    send_bit(1);
    start         = 1'b1;
    cfg_pattern   = 3'b000;
    cfg_frame_len = 8'd2;
    tick();
    start = 1'b0;
    send_bit(0);
    send_bit(1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    settle("abort", 1);

    // async reset mid-frame
    push_ev(0, 1, 0);
    start_frame(3'b101, 8'd8);
    send_bit(1);
    send_bit(0);
    send_bit(1);
    send_bit(1);
    chk("pre_rst_cnt", 32'(match_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(match_cnt), 0);
    chk("arst_match", 32'(match), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data       = i[0];
      tick();
      chk("post_rst_idle", 32'(busy), 0);
    end
    data_valid = 1'b0;

    chk("final_q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
